// File: rtl/fib_engine.sv
// fib_engine - iterative Fibonacci / Lucas term generator.
//
// Accepts an index n and a mode over a valid/ready request channel, walks the
// sequence one step per clock, and returns X(n) mod 2^W plus an overflow flag
// over a valid/ready response channel. One request in flight at a time.
//
// Parameters
//   W  result/datapath width (W >= 2)
//   N  index width; maximum index is 2^N-1
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   request valid
//   in_ready   engine idle and able to accept a request
//   in_n       requested index
//   in_mode    0 = Fibonacci (X0=0, X1=1), 1 = Lucas (X0=2, X1=1)
//   abort      cancel the computation in progress (ignored in IDLE/DONE)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   X(n) mod 2^W
//   out_ovf    true X(n) >= 2^W
//   busy       computation in progress (SEED or CALC)
//
// State | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request; in_ready=1
// SEED  | load a=X0, b=X1 for the latched mode, clear overflow, k=0
// CALC  | step the recurrence until k==n, then capture a
// DONE  | result presented; out_valid=1 until out_ready

module fib_engine #(
  parameter int W = 16,
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_n,
  input  logic         in_mode,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEED = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [N-1:0] n_q;
  logic         mode_q;
  logic [N-1:0] k;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ovf_a;
  logic         ovf_b;
  logic [W:0]   sum;
  logic         at_n;

  // Sum is one bit wider than the datapath; bit W is the carry out.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign at_n = (k == n_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid)   state_nxt = S_SEED;
      S_SEED: state_nxt = abort ? S_IDLE : S_CALC;
      S_CALC: begin
        if (abort)     state_nxt = S_IDLE;
        else if (at_n) state_nxt = S_DONE;
      end
      S_DONE: if (out_ready)  state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q      <= '0;
      mode_q   <= 1'b0;
      k        <= '0;
      a        <= '0;
      b        <= '0;
      ovf_a    <= 1'b0;
      ovf_b    <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            n_q    <= in_n;
            mode_q <= in_mode;
          end
        end
        S_SEED: begin
          // Seeding is harmless on abort: the registers are reloaded before use.
          a     <= mode_q ? W'(2) : W'(0);
          b     <= W'(1);
          ovf_a <= 1'b0;
          ovf_b <= 1'b0;
          k     <= '0;
        end
        S_CALC: begin
          if (!abort) begin
            if (at_n) begin
              out_data <= a;
              out_ovf  <= ovf_a;
            end else begin
              // Overflow is sticky and trails b by one step, so a wrap that
              // only reaches X(n+1) never marks the returned X(n).
              a     <= b;
              b     <= sum[W-1:0];
              ovf_a <= ovf_b;
              ovf_b <= sum[W] | ovf_a | ovf_b;
              k     <= k + N'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_SEED) || (state == S_CALC);

endmodule

// File: tb/tb_fib_engine.sv
module tb_fib_engine;

  localparam int NI = 6;

  logic          clk = 1'b0;
  logic          rst;

  logic          in_valid, in_mode, abort, out_ready;
  logic [NI-1:0] in_n;
  logic          in_ready, out_valid, out_ovf, busy;
  logic [7:0]    out_data;

  logic          in_valid16, in_mode16, abort16, out_ready16;
  logic [NI-1:0] in_n16;
  logic          in_ready16, out_valid16, out_ovf16, busy16;
  logic [15:0]   out_data16;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  fib_engine #(.W(8), .N(NI)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n), .in_mode(in_mode),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .busy(busy)
  );

  fib_engine #(.W(16), .N(NI)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_n(in_n16), .in_mode(in_mode16),
    .abort(abort16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
    .out_ovf(out_ovf16), .busy(busy16)
  );

  typedef struct {
    logic       mode;
    logic [5:0] n;
    logic [7:0] data;
    logic       ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Plain 64-bit reference: no wrap for any index up to 63.
  function automatic logic [63:0] seq_ref(input logic mode, input int n);
    logic [63:0] x0, x1, t;
    x0 = mode ? 64'd2 : 64'd0;
    x1 = 64'd1;
    for (int i = 0; i < n; i++) begin
      t  = x0 + x1;
      x0 = x1;
      x1 = t;
    end
    return x0;
  endfunction

  // Issue one request on the W=8 engine with out_ready=1 and check the result.
  task automatic run_req(input logic mode, input logic [5:0] n, input logic [7:0] exp_d,
                         input logic exp_o, input string name);
    int cyc;
    bit done;
    @(negedge clk);
    in_valid = 1'b1;
    in_n     = n;
    in_mode  = mode;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) done = 1'b1;
    end
    check({name, " out_valid"}, 64'(done), 64'd1);
    if (done) begin
      check({name, " latency"}, 64'(cyc), 64'(int'(n) + 2));
      check({name, " data"}, 64'(out_data), 64'(exp_d));
      check({name, " ovf"}, 64'(out_ovf), 64'(exp_o));
      @(posedge clk);
      #1;
      check({name, " in_ready after"}, 64'(in_ready), 64'd1);
      check({name, " out_valid after"}, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  seen;
    logic [63:0] ref63;

    rst = 1'b1;
    in_valid = 1'b0; in_n = '0; in_mode = 1'b0; abort = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; in_n16 = '0; in_mode16 = 1'b0; abort16 = 1'b0; out_ready16 = 1'b1;

    vecs[0] = '{1'b0, 6'd13, 8'd233, 1'b0};
    vecs[1] = '{1'b0, 6'd14, 8'd121, 1'b1};
    vecs[2] = '{1'b1, 6'd0,  8'd2,   1'b0};
    vecs[3] = '{1'b1, 6'd1,  8'd1,   1'b0};
    vecs[4] = '{1'b1, 6'd5,  8'd11,  1'b0};
    vecs[5] = '{1'b1, 6'd11, 8'd199, 1'b0};
    vecs[6] = '{1'b1, 6'd12, 8'd66,  1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_ovf", 64'(out_ovf), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_req(vecs[i].mode, vecs[i].n, vecs[i].data, vecs[i].ovf, $sformatf("vec%0d", i));

    // Backpressure: Lucas n=5 held in DONE; a second request waits on in_valid.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_n = 6'd5; in_mode = 1'b1;
    @(posedge clk);
    #1;
    in_n = 6'd7; in_mode = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) seen = 1'b1;
    end
    check("bp first latency", 64'(cyc), 64'd7);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp held data", 64'(out_data), 64'd11);
      check("bp held in_ready", 64'(in_ready), 64'd0);
      check("bp held out_valid", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release in_ready", 64'(in_ready), 64'd1);
    check("bp release out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp second accepted", 64'(busy), 64'd1);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) seen = 1'b1;
    end
    check("bp second latency", 64'(cyc), 64'd9);
    check("bp second data", 64'(out_data), 64'd13);
    check("bp second ovf", 64'(out_ovf), 64'd0);
    @(posedge clk);
    #1;

    // Abort at the third CALC cycle of n=20.
    @(negedge clk);
    in_valid = 1'b1; in_n = 6'd20; in_mode = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    check("abort busy before", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort busy", 64'(busy), 64'd0);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort data kept", 64'(out_data), 64'd13);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort no response", 64'(seen), 64'd0);

    // Abort during DONE is ignored.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_n = 6'd1; in_mode = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) seen = 1'b1;
    end
    check("done-abort latency", 64'(cyc), 64'd3);
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("done-abort out_valid", 64'(out_valid), 64'd1);
    check("done-abort data", 64'(out_data), 64'd1);
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("done-abort delivered", 64'(out_valid), 64'd0);
    check("done-abort in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    in_valid = 1'b1; in_n = 6'd30; in_mode = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre-rst busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_ovf", 64'(out_ovf), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_req(1'b0, 6'd10, 8'd55, 1'b0, "fib10 after rst");

    // Maximum index on the 16-bit engine.
    ref63 = seq_ref(1'b0, 63);
    @(negedge clk);
    in_valid16 = 1'b1; in_n16 = 6'd63; in_mode16 = 1'b0;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid16) seen = 1'b1;
    end
    check("max out_valid", 64'(seen), 64'd1);
    check("max latency", 64'(cyc), 64'd65);
    check("max data", 64'(out_data16), {48'd0, ref63[15:0]});
    check("max ovf", 64'(out_ovf16), 64'(ref63 >= 64'd65536));
    @(posedge clk);
    #1;
    check("max consumed", 64'(out_valid16), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fib_engine.md
# fib_engine

Parametrised sequence engine, successor to the fixed-width Fibonacci controller. It merges control and datapath in one block. It accepts an index `n` and a mode over a valid/ready request channel. It computes the Fibonacci or Lucas term X(n) iteratively, one step per clock, then returns the result with an overflow flag over a valid/ready response channel. It sits between the command front end and the result collector, and replaces the separate fsm/datapath pair.

## Interface
- `W`, default 16: result/datapath width in bits; legal values are W ≥ 2.
- `N`, default 6: index width in bits; maximum index is 2^N−1.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: request valid.
- `in_ready`, out, 1: engine can accept a request.
- `in_n`, in, N: requested index n.
- `in_mode`, in, 1: 0 = Fibonacci (X0=0, X1=1); 1 = Lucas (X0=2, X1=1).
- `abort`, in, 1: cancel the computation in progress.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `out_data`, out, W: X(n) mod 2^W.
- `out_ovf`, out, 1: true X(n) ≥ 2^W.
- `busy`, out, 1: state is SEED or CALC.

## Operation
- **States:**
  - **IDLE:** `in_ready`=1. On `in_valid`, latch `in_n` and `in_mode`, then go to SEED.
  - **SEED:** load a=X0 and b=X1 for the latched mode, clear ovf_a/ovf_b, set k=0, then go to CALC.
  - **CALC:** if k==n, copy a→`out_data` and ovf_a→`out_ovf`, then go to DONE.
    - Otherwise step: a←b; b←(a+b) mod 2^W; ovf_a←ovf_b; ovf_b←carry(a+b) | ovf_a | ovf_b; k←k+1.
  - **DONE:** `out_valid`=1, with `out_data`/`out_ovf` held stable. When `out_ready`=1, go to IDLE.
  - **Illegal encoding:** go to IDLE.
- **Abort:** `abort` in SEED or CALC forces IDLE on the next edge; no response is produced and `out_data` is unchanged. `abort` in IDLE or DONE is ignored.
- **Overflow tracking:** the two-stage overflow pipeline flags only wrap that reaches a. Overflow when computing X(n+1) in the final step does not set `out_ovf`.
- **Widths:** k is N bits. k never wraps because it stops at n ≤ 2^N−1. The sum is formed at W+1 bits; the carry is bit W.
- **No pipelining:** a new request is accepted only in IDLE; there is one request in flight at a time.
- **Reset values:** state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_ovf`=0, `busy`=0, all internal registers 0.

## Timing
- Accept edge E0 (`in_valid`&`in_ready`):
  - SEED is active during the cycle after E0.
  - CALC lasts n+1 cycles.
  - `out_valid` rises after edge E0+n+2.
- Latency, accept to `out_valid`: n+2 cycles. For n=0 this is 2 cycles.
- `out_valid`&`out_ready` at edge Ed: `in_ready`=1 from Ed onward. The next accept can occur at Ed+1, so the minimum request spacing is n+4 cycles.
- `in_ready` and `out_valid` are state decodes (registered state), with no combinational path from inputs.
- Backpressure: while `out_ready`=0, DONE is held indefinitely with outputs stable.
- `rst` mid-computation: immediate return to the reset values above; the pending request is discarded.

## Test plan
- **Fibonacci:** W=8, mode=0, n=13 → `out_data`=233, `out_ovf`=0 (X14 wrap in b must not flag); `out_valid` 15 cycles after accept. Then n=14 → 121, `out_ovf`=1.
- **Lucas and small n:** mode=1 with n=0 → 2; n=1 → 1; n=5 → 11; n=11 → 199/ovf=0; n=12 → 66/ovf=1 (322 mod 256).
- **Backpressure and back-to-back:**
  - Hold `out_ready`=0 for 10 cycles → `out_data` stable, `in_ready`=0, and a new `in_valid` is not accepted.
  - Release → `in_ready`=1 next cycle; the second request (mode=0, n=7) returns 13.
- **Abort:** assert `abort` at the 3rd CALC cycle of n=20 → IDLE next cycle, no `out_valid`, previous `out_data` retained. `abort` during DONE → ignored, result still delivered.
- **Reset mid-CALC:** assert `rst` asynchronously mid-CALC → all outputs return to reset values immediately. After release, a fresh request (mode=0, n=10) returns 55.
- **Max index:** N=6, W=16, mode=0, n=63 → `out_ovf`=1 and `out_data`=F(63) mod 65536, matching a reference model; latency 65 cycles.
